// File: rtl/cache_pkg.sv
// Shared types and width helpers for the data cache.
// Holds the controller state enum and the offset/index/tag width functions.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } cache_state_e;

    // Word-offset bits inside a line.
    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Set-index bits.
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: whatever remains above index, offset and the byte bits.
    function automatic int tag_bits(input int addr_w, input int sets,
                                    input int words_per_line);
        return addr_w - $clog2(sets) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Ports: combinational read (rd_*), word write (wr_*), tag+valid write
// (tag_*), and rst which invalidates every line.
module cache_line_store #(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int DATA_W         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(SETS)-1:0]           rd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_offset,
    output logic                              rd_valid,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [DATA_W-1:0]                 rd_data,
    input  logic                              wr_en,
    input  logic [$clog2(SETS)-1:0]           wr_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_offset,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              tag_we,
    input  logic [$clog2(SETS)-1:0]           tag_index,
    input  logic [TAG_W-1:0]                  tag_value
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS*WORDS_PER_LINE];

    always_comb begin
        valid_d = valid_q;
        if (tag_we) begin
            valid_d[tag_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[tag_index] <= tag_value;
        end
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_q[rd_index];
        rd_data  = data_q[{rd_index, rd_offset}];
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Ports: cpu_* (core side, stall-based), mem_* (req/ack backing memory),
// hit_count/miss_count statistics, built only with DATA_CACHE_STATS_EN.
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int OFF_W = offset_bits(WORDS_PER_LINE);
    localparam int IDX_W = index_bits(SETS);
    localparam int TAG_W = tag_bits(ADDRESS_WIDTH, SETS, WORDS_PER_LINE);
    localparam int LOW_W = OFF_W + 2;

    cache_state_e state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [OFF_W-1:0]         word_cnt_q, word_cnt_d;
    logic                     from_refill_q, from_refill_d;

    logic [IDX_W-1:0] cpu_index;
    logic [OFF_W-1:0] cpu_offset;
    logic [TAG_W-1:0] cpu_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic             hit;
    logic             word_we;
    logic [DATA_WIDTH-1:0] word_data;
    logic             tag_we;
    logic             count_hit;
    logic             count_miss;

    assign cpu_offset = cpu_addr[OFF_W+1 -: OFF_W];
    assign cpu_index  = cpu_addr[IDX_W+LOW_W-1 -: IDX_W];
    assign cpu_tag    = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign hit        = rd_valid && (rd_tag == cpu_tag);

    // Writes always target mem_addr_q: the refill word in flight, or the
    // store address, which equals the held cpu_addr during WRITE.
    cache_line_store #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .DATA_W         (DATA_WIDTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (cpu_index),
        .rd_offset (cpu_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (word_we),
        .wr_index  (mem_addr_q[IDX_W+LOW_W-1 -: IDX_W]),
        .wr_offset (mem_addr_q[OFF_W+1 -: OFF_W]),
        .wr_data   (word_data),
        .tag_we    (tag_we),
        .tag_index (mem_addr_q[IDX_W+LOW_W-1 -: IDX_W]),
        .tag_value (mem_addr_q[ADDRESS_WIDTH-1 -: TAG_W])
    );

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        word_cnt_d    = word_cnt_q;
        from_refill_d = from_refill_q;
        word_we       = 1'b0;
        word_data     = mem_rdata;
        tag_we        = 1'b0;
        count_hit     = 1'b0;
        count_miss    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                    mem_wdata_d = cpu_wdata;
                end else if (cpu_re) begin
                    if (hit) begin
                        count_hit = 1'b1;
                    end else begin
                        state_d    = REFILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_addr[ADDRESS_WIDTH-1:LOW_W],
                                      {LOW_W{1'b0}}};
                        word_cnt_d = '0;
                    end
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    word_we = 1'b1;
                    if (word_cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        tag_we        = 1'b1;
                        mem_req_d     = 1'b0;
                        from_refill_d = 1'b1;
                        state_d       = RESP;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        mem_addr_d = mem_addr_q + ADDRESS_WIDTH'(4);
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    // Write-through: refresh the cached copy only on a hit.
                    word_we       = hit;
                    word_data     = mem_wdata_q;
                    mem_req_d     = 1'b0;
                    from_refill_d = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                count_miss = from_refill_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            word_cnt_q    <= '0;
            from_refill_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            word_cnt_q    <= word_cnt_d;
            from_refill_q <= from_refill_d;
        end
    end

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        unique case (state_q)
            IDLE: begin
                cpu_stall = cpu_we || (cpu_re && !hit);
                if (cpu_re && !cpu_we && hit) begin
                    cpu_rdata = rd_data;
                end
            end
            REFILL: cpu_stall = 1'b1;
            WRITE:  cpu_stall = 1'b1;
            RESP:   cpu_rdata = rd_data;
            default: cpu_stall = 1'b0;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (count_hit && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (count_miss && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    logic unused_addr;
    assign unused_addr = ^cpu_addr[1:0];
`else
    assign hit_count  = '0;
    assign miss_count = '0;

    logic unused_stats;
    assign unused_stats = ^{count_hit, count_miss, cpu_addr[1:0]};
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache (SETS=16, WORDS_PER_LINE=4, L=2).
// Stimulus tasks push expected loads and memory beats; monitors pop them.
module tb_data_cache;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    data_cache #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .SETS           (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_q [$];
    beat_t       beat_q [$];
    logic [31:0] mem [logic [31:0]];
    int          ack_total = 0;
    int          req_run = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Backing memory: ack in the L-th cycle of a held request.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req && !rst) begin
            req_run++;
            if (req_run == L) begin
                beat_t e;
                req_run = 0;
                mem_ack = 1'b1;
                mem_rdata = mem_read(mem_addr);
                ack_total++;
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got addr %h we %b",
                             mem_addr, mem_we);
                end else begin
                    e = beat_q.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
                    if (e.we) begin
                        chk("mem_wdata", mem_wdata, e.wdata);
                        mem[mem_addr] = mem_wdata;
                    end
                end
            end
        end else begin
            req_run = 0;
        end
    end

    // Load-data monitor.
    always @(negedge clk) begin
        if (!rst && cpu_re && !cpu_we && !cpu_stall) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_unexpected: got %h", cpu_rdata);
            end else begin
                chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
            end
        end
    end

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            beat_q.push_back('{we: 1'b0, addr: base + 32'(4 * i),
                               wdata: 32'h0});
        end
    endtask

    // Issue an access and hold it until the stall drops.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output int stalls, output int reqs);
        stalls = 0;
        reqs = 0;
        @(posedge clk);
        #1;
        cpu_we = we;
        cpu_re = !we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (!cpu_stall) break;
            stalls++;
        end
        if (stalls >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d stall cycles expected <100",
                     stalls);
        end
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic load(input string name, input logic [31:0] addr,
                        input logic [31:0] exp, input int exp_stall,
                        input int exp_reqs);
        int s, r;
        rd_q.push_back(exp);
        access(1'b0, addr, 32'h0, s, r);
        chk({name, "_stall"}, 32'(s), 32'(exp_stall));
        chk({name, "_reqs"}, 32'(r), 32'(exp_reqs));
    endtask

    task automatic store(input string name, input logic [31:0] addr,
                         input logic [31:0] data);
        int s, r;
        beat_q.push_back('{we: 1'b1, addr: addr, wdata: data});
        access(1'b1, addr, data, s, r);
        chk({name, "_reqs"}, 32'(r), 32'(L));
    endtask

    task automatic check_reset(input string name);
        chk({name, "_req"}, {31'h0, mem_req}, 32'h0);
        chk({name, "_stall"}, {31'h0, cpu_stall}, 32'h0);
        chk({name, "_rdata"}, cpu_rdata, 32'h0);
        chk({name, "_hits"}, hit_count, 32'h0);
        chk({name, "_misses"}, miss_count, 32'h0);
    endtask

    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
    int          base;

    initial begin
        rst = 1'b1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
`ifdef DATA_CACHE_STATS_EN
        exp_hits = 32'd1;
        exp_miss = 32'd1;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        push_refill(32'h100);
        load("miss_104", 32'h104, 32'hC0DE_0104, 9, 8);
        load("hit_108", 32'h108, 32'hC0DE_0108, 0, 0);
        @(negedge clk);
        chk("stats_hits", hit_count, exp_hits);
        chk("stats_misses", miss_count, exp_miss);

        push_refill(32'h200);
        load("conflict_204", 32'h204, 32'hC0DE_0204, 9, 8);
        push_refill(32'h100);
        load("remiss_104", 32'h104, 32'hC0DE_0104, 9, 8);

        store("st_hit_104", 32'h104, 32'hDEAD_BEEF);
        load("hit_after_st", 32'h104, 32'hDEAD_BEEF, 0, 0);

        store("st_miss_300", 32'h300, 32'h0000_1234);
        push_refill(32'h300);
        load("miss_300", 32'h300, 32'h0000_1234, 9, 8);

        // Abort a refill of 0x600 after its second word.
        beat_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0});
        beat_q.push_back('{we: 1'b0, addr: 32'h604, wdata: 32'h0});
        base = ack_total;
        @(posedge clk);
        #1;
        cpu_re = 1'b1;
        cpu_addr = 32'h600;
        for (int k = 0; k < 100 && ack_total < base + 2; k++) begin
            @(negedge clk);
        end
        chk("abort_acks", 32'(ack_total - base), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("midrefill_rst");

        push_refill(32'h100);
        load("post_rst_104", 32'h104, 32'hDEAD_BEEF, 9, 8);

        repeat (4) @(posedge clk);
        chk("beats_left", 32'(beat_q.size()), 32'd0);
        chk("loads_left", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
